// File: rtl/ans_pkg.sv
// Shared rANS constants and state encoding for the nibble-stream encoder/decoder pair.
package ans_pkg;

  localparam int unsigned SYM_WIDTH   = 4;
  localparam int unsigned STATE_WIDTH = 16;
  localparam int unsigned CNT_WIDTH   = 4;
  localparam int unsigned PROB_BITS   = 4;

  // Lower bound of the normalised state interval [L, L*16).
  localparam logic [STATE_WIDTH-1:0] ANS_L = 16'h1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_DECODE,
    ST_EMIT,
    ST_RENORM,
    ST_DONE
  } ans_state_e;

endpackage

// File: rtl/ans_cum_lookup.sv
// Combinational prefix sum of the frequency table and slot-to-symbol search.
module ans_cum_lookup #(
  parameter int unsigned SYM_WIDTH = ans_pkg::SYM_WIDTH,
  parameter int unsigned CNT_WIDTH = ans_pkg::CNT_WIDTH,
  parameter int unsigned PROB_BITS = ans_pkg::PROB_BITS
) (
  input  logic [(1<<SYM_WIDTH)*CNT_WIDTH-1:0] counts_unpacked,
  input  logic [PROB_BITS-1:0]                slot,
  output logic [SYM_WIDTH-1:0]                s,
  output logic [CNT_WIDTH-1:0]                count,
  output logic [CNT_WIDTH+SYM_WIDTH-1:0]      cum
);
  import ans_pkg::*;

  localparam int unsigned ALPHA = 1 << SYM_WIDTH;
  localparam int unsigned SUM_W = CNT_WIDTH + SYM_WIDTH;

  logic [SUM_W-1:0]     acc;
  logic [CNT_WIDTH-1:0] c_i;
  logic [SUM_W-1:0]     slot_w;

  assign slot_w = SUM_W'(slot);

  // Walk symbols in index order; zero-count symbols have an empty range and never match.
  always_comb begin
    s     = '0;
    count = '0;
    cum   = '0;
    acc   = '0;
    c_i   = '0;
    for (int i = 0; i < ALPHA; i++) begin
      c_i = counts_unpacked[i*CNT_WIDTH +: CNT_WIDTH];
      if ((slot_w >= acc) && (slot_w < acc + SUM_W'(c_i))) begin
        s     = SYM_WIDTH'(i);
        count = c_i;
        cum   = acc;
      end
      acc = acc + SUM_W'(c_i);
    end
  end

endmodule

// File: rtl/ans_stream_decoder.sv
// rANS decoder: loads a 16-bit state from a nibble stream, emits symbols, renormalises one nibble at a time.
module ans_stream_decoder #(
  parameter int unsigned SYM_WIDTH   = ans_pkg::SYM_WIDTH,
  parameter int unsigned STATE_WIDTH = ans_pkg::STATE_WIDTH,
  parameter int unsigned CNT_WIDTH   = ans_pkg::CNT_WIDTH,
  parameter int unsigned PROB_BITS   = ans_pkg::PROB_BITS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [7:0]                          num_syms,
  input  logic [(1<<SYM_WIDTH)*CNT_WIDTH-1:0] counts_unpacked,
  input  logic [PROB_BITS-1:0]                in,
  input  logic                                in_vld,
  output logic                                in_rdy,
  output logic [SYM_WIDTH-1:0]                out,
  output logic                                out_vld,
  input  logic                                out_rdy,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);
  import ans_pkg::*;

  localparam int unsigned ALPHA     = 1 << SYM_WIDTH;
  localparam int unsigned SUM_W     = CNT_WIDTH + SYM_WIDTH;
  localparam int unsigned PROD_W    = STATE_WIDTH + CNT_WIDTH;
  localparam int unsigned REM_W     = 8;
  localparam int unsigned INIT_NIBS = STATE_WIDTH / PROB_BITS;
  localparam int unsigned NCNT_W    = $clog2(INIT_NIBS);
  localparam logic [STATE_WIDTH-1:0] LOW = STATE_WIDTH'(ANS_L);

  ans_state_e state, state_nxt;

  logic [STATE_WIDTH-1:0] x, x_nxt, x_shift, x_dec;
  logic [REM_W-1:0]       remaining;
  logic [NCNT_W-1:0]      nib_cnt;
  logic [SUM_W-1:0]       total;
  logic                   bad_sum;
  logic                   in_xfer, out_xfer, fin_err;
  logic                   in_rdy_nxt, out_vld_nxt, busy_nxt, done_nxt;

  logic [SYM_WIDTH-1:0]   lk_s;
  logic [CNT_WIDTH-1:0]   lk_count;
  logic [SUM_W-1:0]       lk_cum;
  logic [PROD_W-1:0]      prod;

  ans_cum_lookup #(
    .SYM_WIDTH (SYM_WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .PROB_BITS (PROB_BITS)
  ) u_lookup (
    .counts_unpacked (counts_unpacked),
    .slot            (x[PROB_BITS-1:0]),
    .s               (lk_s),
    .count           (lk_count),
    .cum             (lk_cum)
  );

  // Table must sum to exactly M for a valid decode.
  always_comb begin
    total = '0;
    for (int i = 0; i < ALPHA; i++) begin
      total = total + SUM_W'(counts_unpacked[i*CNT_WIDTH +: CNT_WIDTH]);
    end
  end
  assign bad_sum = (total != SUM_W'(1 << PROB_BITS));

  assign in_xfer  = in_vld && in_rdy;
  assign out_xfer = out_vld && out_rdy;
  assign x_shift  = STATE_WIDTH'({x, in});

  // Decode step: x' = f[s] * (x >> 4) + slot - cum[s]; cannot overflow for a valid table.
  always_comb begin
    prod  = PROD_W'(lk_count) * PROD_W'(x >> PROB_BITS)
          + PROD_W'(x[PROB_BITS-1:0]) - PROD_W'(lk_cum);
    x_dec = STATE_WIDTH'(prod);
  end

  // Value the state register takes at the next edge.
  always_comb begin
    x_nxt = x;
    case (state)
      ST_INIT, ST_RENORM: if (in_xfer) x_nxt = x_shift;
      ST_DECODE:          x_nxt = x_dec;
      default:            ;
    endcase
  end

  // End-of-job check: the final state must land exactly on L.
  assign fin_err = (state != ST_IDLE) && (state != ST_DONE) &&
                   (state_nxt == ST_DONE) && (x_nxt != LOW);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = bad_sum ? ST_DONE : ST_INIT;
      end
      ST_INIT: begin
        if (in_xfer && (nib_cnt == NCNT_W'(INIT_NIBS - 1)))
          state_nxt = (remaining == '0) ? ST_DONE : ST_DECODE;
      end
      ST_DECODE: state_nxt = ST_EMIT;
      ST_EMIT: begin
        if (out_xfer) begin
          if (x < LOW)                      state_nxt = ST_RENORM;
          else if (remaining == REM_W'(1))  state_nxt = ST_DONE;
          else                              state_nxt = ST_DECODE;
        end
      end
      ST_RENORM: begin
        if (in_xfer) state_nxt = (remaining == '0) ? ST_DONE : ST_DECODE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake/status outputs decoded from the upcoming state so they register alongside it.
  always_comb begin
    in_rdy_nxt  = 1'b0;
    out_vld_nxt = 1'b0;
    busy_nxt    = (state_nxt != ST_IDLE);
    done_nxt    = 1'b0;
    case (state_nxt)
      ST_INIT, ST_RENORM: in_rdy_nxt  = 1'b1;
      ST_EMIT:            out_vld_nxt = 1'b1;
      ST_DONE:            done_nxt    = 1'b1;
      default:            ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_rdy  <= 1'b0;
      out_vld <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      in_rdy  <= in_rdy_nxt;
      out_vld <= out_vld_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Datapath: state, symbol counter, init nibble counter, decoded symbol, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      remaining <= '0;
      nib_cnt   <= '0;
      out       <= '0;
      err       <= 1'b0;
    end else begin
      x <= x_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= num_syms;
            nib_cnt   <= '0;
          end
        end
        ST_INIT:   if (in_xfer) nib_cnt <= nib_cnt + NCNT_W'(1);
        ST_DECODE: out <= lk_s;
        ST_EMIT:   if (out_xfer) remaining <= remaining - REM_W'(1);
        default:   ;
      endcase
      if ((state == ST_IDLE) && start) err <= bad_sum;
      else if (fin_err)                err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ans_stream_decoder.sv
// Scoreboard bench for ans_stream_decoder using hand-computed rANS vectors.
module tb_ans_stream_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_syms;
  logic [63:0] counts_unpacked;
  logic [3:0]  in;
  logic        in_vld;
  logic        in_rdy;
  logic [3:0]  out;
  logic        out_vld;
  logic        out_rdy;
  logic        busy;
  logic        done;
  logic        err;

  localparam logic [63:0] UNIFORM = 64'h1111_1111_1111_1111;
  localparam logic [63:0] SKEWED  = 64'h0000_0000_0000_001F;
  localparam logic [63:0] SUM15   = 64'h0000_0000_0000_000F;

  always #5 clk = ~clk;

  ans_stream_decoder dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_syms        (num_syms),
    .counts_unpacked (counts_unpacked),
    .in              (in),
    .in_vld          (in_vld),
    .in_rdy          (in_rdy),
    .out             (out),
    .out_vld         (out_vld),
    .out_rdy         (out_rdy),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  int errors = 0;
  int checks = 0;
  logic [3:0] sym_q[$];
  logic       err_q[$];
  int  nib_taken;
  bit  rdy_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compare every symbol transfer and every done pulse against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_vld && out_rdy) begin
        if (sym_q.size() == 0) fail_now("unexpected_symbol");
        else check("symbol", 32'(out), 32'(sym_q.pop_front()));
        check("in_rdy_in_emit", 32'(in_rdy), 32'd0);
      end
      if (done) begin
        if (err_q.size() == 0) fail_now("unexpected_done");
        else check("err_at_done", 32'(err), 32'(err_q.pop_front()));
      end
    end
  end

  // Count consumed nibbles and any cycle where the DUT offered ready.
  always @(posedge clk) begin
    if (in_vld && in_rdy) nib_taken++;
    if (in_rdy) rdy_seen = 1'b1;
  end

  task automatic start_job(input logic [63:0] c, input logic [7:0] n);
    counts_unpacked = c;
    num_syms        = n;
    start           = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    nib_taken = 0;
    rdy_seen  = 1'b0;
  endtask

  task automatic feed_nib(input logic [3:0] v);
    int t;
    t      = 0;
    in     = v;
    in_vld = 1'b1;
    @(negedge clk);
    while (!in_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_rdy) fail_now("in_rdy_timeout");
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 500);
    if (!done) fail_now("done_timeout");
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},    32'(busy),    32'd0);
    check({tag, "_in_rdy"},  32'(in_rdy),  32'd0);
    check({tag, "_out_vld"}, 32'(out_vld), 32'd0);
    check({tag, "_done"},    32'(done),    32'd0);
    check({tag, "_err"},     32'(err),     32'd0);
    check({tag, "_out"},     32'(out),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; in = '0; in_vld = 1'b0; out_rdy = 1'b1;
    num_syms = '0; counts_unpacked = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Uniform table, two symbols: 0x1234 -> 4, renorm 0x1235 -> 5, renorm 0x1236 (bad final).
    sym_q.push_back(4'd4); sym_q.push_back(4'd5); err_q.push_back(1'b1);
    start_job(UNIFORM, 8'd2);
    feed_nib(4'd1); feed_nib(4'd2); feed_nib(4'd3);
    feed_nib(4'd4); feed_nib(4'd5); feed_nib(4'd6);
    wait_done(cyc);
    check("t028_nibbles", 32'(nib_taken), 32'd6);
    check("t028_out_held", 32'(out), 32'd5);

    // Reset mid-INIT after two nibbles discards the job.
    start_job(UNIFORM, 8'd1);
    feed_nib(4'd1); feed_nib(4'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("midrst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Uniform table, one symbol: 0x1000 -> 0, renorm 0x1000 (clean end).
    sym_q.push_back(4'd0); err_q.push_back(1'b0);
    start_job(UNIFORM, 8'd1);
    feed_nib(4'd1); feed_nib(4'd0); feed_nib(4'd0); feed_nib(4'd0); feed_nib(4'd0);
    wait_done(cyc);
    check("t029_nibbles", 32'(nib_taken), 32'd5);
    @(negedge clk);
    check("t029_err_after", 32'(err), 32'd0);
    check("t029_busy_after", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Skewed table: 0x1000 -> 0 (x'=0xF00, renorm 0xF007) -> 0 (x'=0xE107, no renorm).
    sym_q.push_back(4'd0); sym_q.push_back(4'd0); err_q.push_back(1'b1);
    start_job(SKEWED, 8'd2);
    feed_nib(4'd1); feed_nib(4'd0); feed_nib(4'd0); feed_nib(4'd0); feed_nib(4'd7);
    in = 4'd9; in_vld = 1'b1;
    wait_done(cyc);
    in_vld = 1'b0;
    check("t030_nibbles", 32'(nib_taken), 32'd5);

    // Table summing to 15: immediate done with error, never ready for input.
    err_q.push_back(1'b1);
    in = 4'd3; in_vld = 1'b1;
    start_job(SUM15, 8'd1);
    wait_done(cyc);
    in_vld = 1'b0;
    check("t031_done_latency", 32'(cyc), 32'd1);
    check("t031_rdy_seen", 32'(rdy_seen), 32'd0);
    check("t031_nibbles", 32'(nib_taken), 32'd0);

    // Backpressure: 0x1237 -> 7 held for 5 stalled cycles, then renorm 0x1230 (bad final).
    out_rdy = 1'b0;
    sym_q.push_back(4'd7); err_q.push_back(1'b1);
    start_job(UNIFORM, 8'd1);
    feed_nib(4'd1); feed_nib(4'd2); feed_nib(4'd3); feed_nib(4'd7);
    cyc = 0;
    while (!out_vld && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_vld) fail_now("out_vld_timeout");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t032_out_vld", 32'(out_vld), 32'd1);
      check("t032_out", 32'(out), 32'd7);
      check("t032_in_rdy", 32'(in_rdy), 32'd0);
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    feed_nib(4'd0);
    wait_done(cyc);
    check("t032_nibbles", 32'(nib_taken), 32'd5);

    check("sym_q_empty", 32'(sym_q.size()), 32'd0);
    check("err_q_empty", 32'(err_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
